// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-requester main-memory arbiter.
//   - FSM state encoding (2 bits; 2'b11 is illegal and recovers to IDLE)
//   - bank-select bit positions inside a word address
//   - default hold-timeout limit and hold-counter width
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10
    } state_t;

    localparam int unsigned BANK_LSB     = 1;
    localparam int unsigned BANK_MSB     = 2;
    localparam int unsigned MAX_HOLD_DEF = 64;
    localparam int unsigned CW_DEF       = 7;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin picker.
//   req0, req1 : pending requests
//   last       : id of the most recent owner (loses a tie)
//   pick       : id of the winner (only meaningful when any=1)
//   any        : at least one request pending
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic pick,
    output logic any
);

    // On a tie the requester that did not own memory last time wins.
    assign pick = (req0 & req1) ? ~last : req1;
    assign any  = req0 | req1;

endmodule

// File: rtl/mem_arbiter.sv
// Burst-lock arbiter sharing one four-bank main memory between the
// instruction cache (requester 0) and the data cache (requester 1).
//   clk, rst            : clock, asynchronous active-low reset
//   req/rd/wr/addr/wdata: per-requester burst lock and memory access
//   gnt0/gnt1           : registered ownership grants
//   stall0/stall1       : requester must hold its current access
//   err0/err1           : memory error, protocol error or hold timeout
//   rdata               : memory read data broadcast to both requesters
//   m_*                 : memory-side strobes, address, data, status
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEF,
    parameter int unsigned CW       = CW_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        rd0,
    input  logic        rd1,
    input  logic        wr0,
    input  logic        wr1,
    input  logic [15:0] addr0,
    input  logic [15:0] addr1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        stall0,
    output logic        stall1,
    output logic [15:0] rdata,
    output logic        err0,
    output logic        err1,
    output logic        m_rd,
    output logic        m_wr,
    output logic [15:0] m_addr,
    output logic [15:0] m_wdata,
    input  logic [15:0] m_rdata,
    input  logic [3:0]  m_busy,
    input  logic        m_stall,
    input  logic        m_err
);

    state_t          state_q;
    logic            last_q;
    logic [CW-1:0]   hold_cnt_q;
    logic            timeout_q;

    logic            pick;
    logic            any_req;
    logic [CW-1:0]   hold_inc;

    logic            own0;
    logic            own1;
    logic            owner;
    logic            sel_rd;
    logic            sel_wr;
    logic [15:0]     sel_addr;
    logic [15:0]     sel_wdata;
    logic            bank_busy;
    logic            proto_err;
    logic            stall_own;
    logic            err_own;

    rr_pick2 u_pick (
        .req0 (req0),
        .req1 (req1),
        .last (last_q),
        .pick (pick),
        .any  (any_req)
    );

    // Saturating hold count for the current owner.
    assign hold_inc = (hold_cnt_q == CW'(MAX_HOLD)) ? hold_cnt_q : hold_cnt_q + CW'(1);

    // Ownership FSM with last-owner, hold counter and sticky timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            last_q     <= 1'b1;
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    hold_cnt_q <= '0;
                    timeout_q  <= 1'b0;
                    if (any_req) begin
                        state_q <= pick ? ST_OWN1 : ST_OWN0;
                    end
                end
                ST_OWN0: begin
                    if (!req0) begin
                        last_q     <= 1'b0;
                        hold_cnt_q <= '0;
                        timeout_q  <= 1'b0;
                        state_q    <= req1 ? ST_OWN1 : ST_IDLE;
                    end else begin
                        hold_cnt_q <= hold_inc;
                        timeout_q  <= timeout_q | (hold_inc == CW'(MAX_HOLD));
                    end
                end
                ST_OWN1: begin
                    if (!req1) begin
                        last_q     <= 1'b1;
                        hold_cnt_q <= '0;
                        timeout_q  <= 1'b0;
                        state_q    <= req0 ? ST_OWN0 : ST_IDLE;
                    end else begin
                        hold_cnt_q <= hold_inc;
                        timeout_q  <= timeout_q | (hold_inc == CW'(MAX_HOLD));
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    hold_cnt_q <= '0;
                    timeout_q  <= 1'b0;
                end
            endcase
        end
    end

    assign own0  = (state_q == ST_OWN0);
    assign own1  = (state_q == ST_OWN1);
    assign owner = own0 | own1;

    // Route the owner's access; everything reads as zero with no owner.
    always_comb begin
        sel_rd    = 1'b0;
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (own0) begin
            sel_rd    = rd0;
            sel_wr    = wr0;
            sel_addr  = addr0;
            sel_wdata = wdata0;
        end else if (own1) begin
            sel_rd    = rd1;
            sel_wr    = wr1;
            sel_addr  = addr1;
            sel_wdata = wdata1;
        end
    end

    assign bank_busy = m_busy[sel_addr[BANK_MSB:BANK_LSB]];
    assign proto_err = owner & sel_rd & sel_wr;
    assign stall_own = bank_busy | m_stall;
    assign err_own   = m_err | timeout_q | proto_err;

    assign gnt0    = own0;
    assign gnt1    = own1;
    assign m_rd    = owner & sel_rd & ~sel_wr & ~bank_busy;
    assign m_wr    = owner & sel_wr & ~sel_rd & ~bank_busy;
    assign m_addr  = sel_addr;
    assign m_wdata = sel_wdata;
    assign stall0  = own0 ? stall_own : 1'b1;
    assign stall1  = own1 ? stall_own : 1'b1;
    assign err0    = own0 & err_own;
    assign err1    = own1 & err_own;
    assign rdata   = m_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// run compared against a behavioural ownership model.
module tb_mem_arbiter;

    localparam int MAX_HOLD = 64;

    logic        clk;
    logic        rst;
    logic        req0, req1, rd0, rd1, wr0, wr1;
    logic [15:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, stall0, stall1, err0, err1;
    logic [15:0] rdata;
    logic        m_rd, m_wr;
    logic [15:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_busy;
    logic        m_stall, m_err;

    int n_checks;
    int n_errors;

    // Behavioural model: who owns memory, who owned it last, how long held.
    int m_owner;
    int m_last;
    int m_held;

    logic        e_gnt0, e_gnt1, e_stall0, e_stall1, e_err0, e_err1, e_m_rd, e_m_wr;
    logic [15:0] e_m_addr, e_m_wdata;

    mem_arbiter #(.MAX_HOLD(64), .CW(7)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .rd0(rd0), .rd1(rd1), .wr0(wr0), .wr1(wr1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .stall0(stall0), .stall1(stall1),
        .rdata(rdata), .err0(err0), .err1(err1),
        .m_rd(m_rd), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_busy(m_busy), .m_stall(m_stall), .m_err(m_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_owner = -1;
        m_last  = 1;
        m_held  = 0;
    endtask

    // Advance the model by one clock edge using the inputs seen at the edge.
    task automatic model_step();
        logic r[2];
        r[0] = req0;
        r[1] = req1;
        if (!rst) begin
            model_reset();
        end else if (m_owner < 0) begin
            if (r[0] && r[1]) m_owner = 1 - m_last;
            else if (r[0])    m_owner = 0;
            else if (r[1])    m_owner = 1;
            m_held = 0;
        end else if (!r[m_owner]) begin
            m_last  = m_owner;
            m_owner = r[1 - m_owner] ? 1 - m_owner : -1;
            m_held  = 0;
        end else if (m_held < MAX_HOLD) begin
            m_held = m_held + 1;
        end
    endtask

    // Expected outputs for the current model state and current inputs.
    task automatic model_expect();
        logic        r, w, busy;
        logic [15:0] a, d;
        logic [1:0]  bank;
        e_gnt0 = (m_owner == 0);
        e_gnt1 = (m_owner == 1);
        e_stall0 = 1'b1; e_stall1 = 1'b1;
        e_err0 = 1'b0;   e_err1 = 1'b0;
        e_m_rd = 1'b0;   e_m_wr = 1'b0;
        e_m_addr = 16'h0; e_m_wdata = 16'h0;
        if (m_owner >= 0) begin
            r    = (m_owner == 1) ? rd1 : rd0;
            w    = (m_owner == 1) ? wr1 : wr0;
            a    = (m_owner == 1) ? addr1 : addr0;
            d    = (m_owner == 1) ? wdata1 : wdata0;
            bank = 2'((a / 2) % 4);
            busy = m_busy[bank];
            e_m_rd    = r && !w && !busy;
            e_m_wr    = w && !r && !busy;
            e_m_addr  = a;
            e_m_wdata = d;
            if (m_owner == 0) begin
                e_stall0 = busy || m_stall;
                e_err0   = m_err || (m_held >= MAX_HOLD) || (r && w);
            end else begin
                e_stall1 = busy || m_stall;
                e_err1   = m_err || (m_held >= MAX_HOLD) || (r && w);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic settle();
        #2;
        model_expect();
    endtask

    task automatic idle_inputs();
        req0 = 0; req1 = 0; rd0 = 0; rd1 = 0; wr0 = 0; wr1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        m_rdata = 0; m_busy = 0; m_stall = 0; m_err = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        model_reset();
        #1;
        n_checks++;
        if ({gnt0, gnt1, stall0, stall1, err0, err1, m_rd, m_wr} !== 8'b0011_0000) begin
            n_errors++;
            $display("FAIL reset_ctrl: got %b want 00110000",
                     {gnt0, gnt1, stall0, stall1, err0, err1, m_rd, m_wr});
        end
        n_checks++;
        if (m_addr !== 16'h0 || m_wdata !== 16'h0) begin
            n_errors++;
            $display("FAIL reset_bus: addr=%h wdata=%h want 0", m_addr, m_wdata);
        end
        tick(); tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_grant_read();
        idle_inputs();
        req0 = 1;
        tick();
        rd0 = 1; addr0 = 16'h1A42; m_rdata = 16'hBEEF;
        settle();
        n_checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            n_errors++;
            $display("FAIL grant_latency: gnt0=%b gnt1=%b want 1 0", gnt0, gnt1);
        end
        n_checks++;
        if (m_rd !== 1'b1 || m_addr !== 16'h1A42 || stall0 !== 1'b0 || rdata !== 16'hBEEF) begin
            n_errors++;
            $display("FAIL grant_read: m_rd=%b m_addr=%h stall0=%b rdata=%h want 1 1a42 0 beef",
                     m_rd, m_addr, stall0, rdata);
        end
        idle_inputs();
        tick(); tick();
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        req0 = 1;
        tick();
        req1 = 1;
        for (int i = 0; i < 4; i++) tick();
        req0 = 0;
        settle();
        n_checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            n_errors++;
            $display("FAIL handover_hold: gnt0=%b gnt1=%b want 1 0", gnt0, gnt1);
        end
        tick();
        settle();
        n_checks++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b1) begin
            n_errors++;
            $display("FAIL handover_switch: gnt0=%b gnt1=%b want 0 1", gnt0, gnt1);
        end
        req1 = 0;
        tick();
        req0 = 1; req1 = 1;
        tick();
        settle();
        n_checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            n_errors++;
            $display("FAIL tie_after_own1: gnt0=%b gnt1=%b want 1 0", gnt0, gnt1);
        end
        idle_inputs();
        tick(); tick();
    endtask

    task automatic test_bank_busy();
        idle_inputs();
        req0 = 1;
        tick();
        wr0 = 1; addr0 = 16'h0004; wdata0 = 16'h5A5A; m_busy = 4'b0100;
        settle();
        n_checks++;
        if (m_wr !== 1'b0 || stall0 !== 1'b1 || m_addr !== 16'h0004 || m_wdata !== 16'h5A5A) begin
            n_errors++;
            $display("FAIL bank_gated: m_wr=%b stall0=%b addr=%h wdata=%h want 0 1 0004 5a5a",
                     m_wr, stall0, m_addr, m_wdata);
        end
        tick();
        m_busy = 4'b0000;
        settle();
        n_checks++;
        if (m_wr !== 1'b1 || stall0 !== 1'b0) begin
            n_errors++;
            $display("FAIL bank_free: m_wr=%b stall0=%b want 1 0", m_wr, stall0);
        end
        idle_inputs();
        tick(); tick();
    endtask

    task automatic test_timeout();
        idle_inputs();
        req1 = 1;
        tick();
        for (int i = 0; i < 70; i++) begin
            settle();
            n_checks++;
            if (err1 !== (i >= MAX_HOLD) || err0 !== 1'b0 || gnt1 !== 1'b1) begin
                n_errors++;
                $display("FAIL timeout_cycle%0d: err1=%b err0=%b gnt1=%b want %b 0 1",
                         i, err1, err0, gnt1, (i >= MAX_HOLD));
            end
            tick();
        end
        rd1 = 1; wr1 = 1;
        settle();
        n_checks++;
        if (m_rd !== 1'b0 || m_wr !== 1'b0 || err1 !== 1'b1) begin
            n_errors++;
            $display("FAIL proto_err: m_rd=%b m_wr=%b err1=%b want 0 0 1", m_rd, m_wr, err1);
        end
        idle_inputs();
        tick();
        settle();
        n_checks++;
        if (err1 !== 1'b0 || gnt1 !== 1'b0) begin
            n_errors++;
            $display("FAIL timeout_clear: err1=%b gnt1=%b want 0 0", err1, gnt1);
        end
        tick();
    endtask

    task automatic test_merr_nonowner();
        idle_inputs();
        req0 = 1;
        tick();
        m_err = 1; rd1 = 1; addr1 = 16'h0002;
        settle();
        n_checks++;
        if (err0 !== 1'b1 || err1 !== 1'b0 || m_rd !== 1'b0 || stall1 !== 1'b1) begin
            n_errors++;
            $display("FAIL merr_pulse: err0=%b err1=%b m_rd=%b stall1=%b want 1 0 0 1",
                     err0, err1, m_rd, stall1);
        end
        tick();
        m_err = 0;
        settle();
        n_checks++;
        if (err0 !== 1'b0 || err1 !== 1'b0) begin
            n_errors++;
            $display("FAIL merr_end: err0=%b err1=%b want 0 0", err0, err1);
        end
        idle_inputs();
        tick(); tick();
    endtask

    task automatic test_reset_midburst();
        idle_inputs();
        req1 = 1;
        tick();
        wr1 = 1; addr1 = 16'h0010; wdata1 = 16'h1234;
        settle();
        n_checks++;
        if (m_wr !== 1'b1 || gnt1 !== 1'b1) begin
            n_errors++;
            $display("FAIL midburst_pre: m_wr=%b gnt1=%b want 1 1", m_wr, gnt1);
        end
        rst = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (m_wr !== 1'b0 || gnt1 !== 1'b0 || stall1 !== 1'b1 || m_addr !== 16'h0) begin
            n_errors++;
            $display("FAIL midburst_reset: m_wr=%b gnt1=%b stall1=%b addr=%h want 0 0 1 0000",
                     m_wr, gnt1, stall1, m_addr);
        end
        tick();
        rst = 1'b1;
        idle_inputs();
        req0 = 1; req1 = 1;
        tick();
        settle();
        n_checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            n_errors++;
            $display("FAIL post_reset_tie: gnt0=%b gnt1=%b want 1 0", gnt0, gnt1);
        end
        idle_inputs();
        tick(); tick();
    endtask

    task automatic test_random();
        idle_inputs();
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 199) != 0);
            #1;
            if (!rst) model_reset();
            if ($urandom_range(0, 7) == 0) req0 = ~req0;
            if ($urandom_range(0, 7) == 0) req1 = ~req1;
            rd0 = 1'($urandom); wr0 = ($urandom_range(0, 3) == 0);
            rd1 = 1'($urandom); wr1 = ($urandom_range(0, 3) == 0);
            addr0 = 16'($urandom); addr1 = 16'($urandom);
            wdata0 = 16'($urandom); wdata1 = 16'($urandom);
            m_rdata = 16'($urandom);
            m_busy = 4'($urandom);
            m_stall = ($urandom_range(0, 7) == 0);
            m_err = ($urandom_range(0, 15) == 0);
            settle();
            n_checks++;
            if ({gnt0, gnt1, stall0, stall1, err0, err1, m_rd, m_wr} !==
                {e_gnt0, e_gnt1, e_stall0, e_stall1, e_err0, e_err1, e_m_rd, e_m_wr}) begin
                n_errors++;
                $display("FAIL rand_ctrl%0d: got %b want %b", i,
                         {gnt0, gnt1, stall0, stall1, err0, err1, m_rd, m_wr},
                         {e_gnt0, e_gnt1, e_stall0, e_stall1, e_err0, e_err1, e_m_rd, e_m_wr});
            end
            n_checks++;
            if (m_addr !== e_m_addr || m_wdata !== e_m_wdata || rdata !== m_rdata) begin
                n_errors++;
                $display("FAIL rand_bus%0d: addr=%h wdata=%h rdata=%h want %h %h %h", i,
                         m_addr, m_wdata, rdata, e_m_addr, e_m_wdata, m_rdata);
            end
            n_checks++;
            if (gnt0 && gnt1) begin
                n_errors++;
                $display("FAIL rand_overlap%0d: gnt0=%b gnt1=%b want at most one", i, gnt0, gnt1);
            end
            tick();
        end
        rst = 1'b1;
        idle_inputs();
        tick(); tick();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        model_reset();
        test_reset();
        test_grant_read();
        test_back_to_back();
        test_bank_busy();
        test_timeout();
        test_merr_nonowner();
        test_reset_midburst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
